// File: rtl/usb_msc_bot_host.sv
// USB Mass Storage Bulk-Only-Transport host: serialises the CBW, moves the data
// phase between user streams and the bulk pipes, then collects and checks the CSW.
module usb_msc_bot_host #(
    parameter int MAXPKT     = 64,
    parameter int BLOCK_SIZE = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_lba,
    input  logic [15:0] cmd_len,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic [1:0]  status,
    output logic        busy
);

    localparam int               PKT_W    = (MAXPKT > 1) ? $clog2(MAXPKT) : 1;
    localparam logic [PKT_W-1:0] PKT_END  = PKT_W'(MAXPKT - 1);
    localparam logic [31:0]      CBW_LAST = 32'd30;
    localparam logic [31:0]      CSW_LAST = 32'd12;
    localparam logic [31:0]      CSW_HDR  = 32'd8;
    localparam logic [31:0]      CSW_SIG  = 32'h5342_5355;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CBW,
        S_DATA_OUT,
        S_DATA_IN,
        S_CSW,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [31:0]      r_tag;
    logic             r_write;
    logic [31:0]      r_lba;
    logic [15:0]      r_len;
    logic [31:0]      r_byte_cnt;
    logic [PKT_W-1:0] r_pkt_cnt;
    logic [63:0]      r_csw_hdr;
    logic [7:0]       r_rd_data;
    logic             r_rd_valid;
    logic [1:0]       r_status;

    logic [31:0]      w_total;
    logic             w_last_data;
    logic [7:0]       w_opcode;
    logic [7:0]       w_cbw_byte;
    logic [1:0]       w_csw_status;

    assign w_total     = 32'(r_len) * 32'(BLOCK_SIZE);
    assign w_last_data = (r_byte_cnt == w_total - 32'd1);
    assign w_opcode    = r_write ? 8'h2A : 8'h28;

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign status   = r_status;

    // CBW layout: signature, tag (LE), transfer length (LE), flags, LUN, CB length, then the 10-byte CDB.
    always_comb begin
        w_cbw_byte = 8'h00;
        case (r_byte_cnt[4:0])
            5'd0:  w_cbw_byte = 8'h55;
            5'd1:  w_cbw_byte = 8'h53;
            5'd2:  w_cbw_byte = 8'h42;
            5'd3:  w_cbw_byte = 8'h43;
            5'd4:  w_cbw_byte = r_tag[7:0];
            5'd5:  w_cbw_byte = r_tag[15:8];
            5'd6:  w_cbw_byte = r_tag[23:16];
            5'd7:  w_cbw_byte = r_tag[31:24];
            5'd8:  w_cbw_byte = w_total[7:0];
            5'd9:  w_cbw_byte = w_total[15:8];
            5'd10: w_cbw_byte = w_total[23:16];
            5'd11: w_cbw_byte = w_total[31:24];
            5'd12: w_cbw_byte = r_write ? 8'h00 : 8'h80;
            5'd14: w_cbw_byte = 8'h0A;
            5'd15: w_cbw_byte = w_opcode;
            5'd17: w_cbw_byte = r_lba[31:24];
            5'd18: w_cbw_byte = r_lba[23:16];
            5'd19: w_cbw_byte = r_lba[15:8];
            5'd20: w_cbw_byte = r_lba[7:0];
            5'd22: w_cbw_byte = r_len[15:8];
            5'd23: w_cbw_byte = r_len[7:0];
            default: w_cbw_byte = 8'h00;
        endcase
    end

    // The status byte is evaluated as it arrives, so the verdict is ready on the 13th byte.
    always_comb begin
        if (r_csw_hdr[31:0] != CSW_SIG || r_csw_hdr[63:32] != r_tag)
            w_csw_status = 2'd2;
        else if (in_data == 8'h02)
            w_csw_status = 2'd2;
        else if (in_data != 8'h00)
            w_csw_status = 2'd1;
        else
            w_csw_status = 2'd0;
    end

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // NOTE: every combinational output gets a default before the case, so no
    // path through the block leaves a signal unassigned and infers a latch.
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        in_ready  = 1'b0;
        wr_ready  = 1'b0;
        done      = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    w_next = S_CBW;
            end
            S_CBW: begin
                out_valid = 1'b1;
                out_data  = w_cbw_byte;
                out_last  = (r_byte_cnt == CBW_LAST);
                if (out_ready && r_byte_cnt == CBW_LAST) begin
                    if (r_len == 16'd0)
                        w_next = S_CSW;
                    else if (r_write)
                        w_next = S_DATA_OUT;
                    else
                        w_next = S_DATA_IN;
                end
            end
            S_DATA_OUT: begin
                out_valid = wr_valid;
                out_data  = wr_data;
                out_last  = (r_pkt_cnt == PKT_END) || w_last_data;
                wr_ready  = out_ready;
                if (wr_valid && out_ready && w_last_data)
                    w_next = S_CSW;
            end
            S_DATA_IN: begin
                in_ready = 1'b1;
                if (in_valid && w_last_data)
                    w_next = S_CSW;
            end
            S_CSW: begin
                in_ready = 1'b1;
                if (in_valid && r_byte_cnt == CSW_LAST)
                    w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag      <= 32'd1;
            r_write    <= 1'b0;
            r_lba      <= 32'd0;
            r_len      <= 16'd0;
            r_byte_cnt <= 32'd0;
            r_pkt_cnt  <= '0;
            r_csw_hdr  <= 64'd0;
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
            r_status   <= 2'd0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_write    <= cmd_write;
                        r_lba      <= cmd_lba;
                        r_len      <= cmd_len;
                        r_byte_cnt <= 32'd0;
                        r_pkt_cnt  <= '0;
                    end
                end
                S_CBW: begin
                    if (out_ready) begin
                        if (r_byte_cnt == CBW_LAST) begin
                            r_byte_cnt <= 32'd0;
                            r_pkt_cnt  <= '0;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 32'd1;
                        end
                    end
                end
                S_DATA_OUT: begin
                    if (wr_valid && out_ready) begin
                        r_pkt_cnt  <= r_pkt_cnt + 1'b1;
                        r_byte_cnt <= w_last_data ? 32'd0 : r_byte_cnt + 32'd1;
                    end
                end
                S_DATA_IN: begin
                    if (in_valid) begin
                        r_rd_data  <= in_data;
                        r_rd_valid <= 1'b1;
                        r_pkt_cnt  <= r_pkt_cnt + 1'b1;
                        r_byte_cnt <= w_last_data ? 32'd0 : r_byte_cnt + 32'd1;
                    end
                end
                S_CSW: begin
                    if (in_valid) begin
                        // Only signature and tag are kept; residue bytes are not checked.
                        if (r_byte_cnt < CSW_HDR)
                            r_csw_hdr <= {in_data, r_csw_hdr[63:8]};
                        if (r_byte_cnt == CSW_LAST) begin
                            r_status   <= w_csw_status;
                            r_byte_cnt <= 32'd0;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 32'd1;
                        end
                    end
                end
                S_DONE: r_tag <= r_tag + 32'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/usb_msc_bot_host.md
Name: usb_msc_bot_host

Overview:
- USB Mass Storage Bulk-Only-Transport initiator (host side). Counterpart to the FPGA USB-disk device function.
- Accepts READ(10)/WRITE(10) block requests from a user port.
- Serialises the 31-byte CBW onto a bulk-OUT byte stream, then moves the data phase between user streams and the bulk pipes.
- Collects and checks the 13-byte CSW from the bulk-IN stream. Sits between the user logic and a USB full-speed host packet engine.

Parameters:
- MAXPKT, 64, bulk max packet size in bytes; out_last asserts every MAXPKT bytes and at phase end.
- BLOCK_SIZE, 512, bytes per logical block; dCBWDataTransferLength = cmd_len*BLOCK_SIZE.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  request valid
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = WRITE(10) 0x2A, 0 = READ(10) 0x28
- cmd_lba  in  32  starting LBA
- cmd_len  in  16  block count; 0 allowed
- out_data  out  8  bulk-OUT byte
- out_valid  out  1  bulk-OUT valid
- out_last  out  1  last byte of current packet
- out_ready  in  1  bulk-OUT accept
- in_data  in  8  bulk-IN byte
- in_valid  in  1  bulk-IN valid
- in_ready  out  1  bulk-IN accept
- wr_data  in  8  user write-data byte
- wr_valid  in  1  user write-data valid
- wr_ready  out  1  user write-data accept
- rd_data  out  8  read-data byte to user
- rd_valid  out  1  read-data valid (no backpressure)
- done  out  1  one-cycle pulse, command complete
- status  out  2  valid with done: 0 pass, 1 CSW fail, 2 phase error/bad CSW
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state=IDLE, tag=1, all counters 0; cmd_ready=1; out_valid/in_ready/wr_ready/rd_valid/done/busy=0; status=0; out_data=0; rd_data=0.
- Handshakes:
  - Transfer on valid&ready in the same cycle.
  - out_valid, once high, holds with stable out_data/out_last until out_ready.
- IDLE:
  - cmd_valid&cmd_ready latches cmd_write, cmd_lba, cmd_len, tag; byte cnt=0; next state CBW.
- CBW: emits 31 bytes, byte index 0..30, in this order:
  - "USBC" = 55 53 42 43
  - tag, 4 bytes little-endian
  - cmd_len*BLOCK_SIZE, 4 bytes little-endian (32-bit; cmd_len zero-extended)
  - flags: 0x80 for read, 0x00 for write
  - LUN = 0x00
  - CB length = 0x0A
  - opcode
  - 0x00
  - LBA, 4 bytes big-endian
  - 0x00
  - cmd_len, 2 bytes big-endian
  - 0x00
  - 6 bytes 0x00
  - out_last on byte 30.
  - After byte 30 is accepted: DATA_OUT if write and len!=0; DATA_IN if read and len!=0; else CSW.
- DATA_OUT:
  - Pass-through: out_data=wr_data, out_valid=wr_valid, wr_ready=out_ready; no added latency.
  - out_last when (bytes_sent mod MAXPKT)==MAXPKT-1 or on the final byte.
  - After cmd_len*BLOCK_SIZE bytes: CSW.
- DATA_IN:
  - in_ready=1; each accepted byte registered to rd_data, with rd_valid pulsed the following cycle (1-cycle latency).
  - After cmd_len*BLOCK_SIZE bytes: CSW.
- CSW:
  - in_ready=1; 13 bytes shifted in.
  - After the 13th byte, checks in priority order:
    1. signature != 53425355h, or tag mismatch: status=2
    2. bCSWStatus==2: status=2
    3. bCSWStatus!=0: status=1
    4. otherwise status=0
  - Next state DONE.
- DONE:
  - done=1 for one cycle, status held until the next done.
  - Tag increments modulo 2^32 (0xFFFFFFFF wraps to 0).
  - Next state IDLE.
- Counters:
  - Data byte counter is 32-bit; maximum 65535*512 = 0x01FFFE00 is not truncated.
  - Packet counter is log2(MAXPKT) bits and resets at each phase start.
- Boundaries:
  - cmd_valid while busy is ignored; no queueing.
  - wr_valid and in_valid outside their own phase are ignored; ready stays 0.
  - No timeout; stalls indefinitely waiting on a peer.
  - rst mid-command aborts immediately to reset values, with no done.

Test Plan:
- Read, lba=0x00000010, len=1; feed 512 IN bytes then CSW 55 53 42 53 01 00 00 00 00 00 00 00 00 -> CBW bytes 8..11 = 00 02 00 00, byte 12 = 80, bytes 17..20 = 00 00 00 10; 512 rd_valid pulses with matching data; done with status 0.
- Write, lba=5, len=2; wr stream 1024 bytes -> out_last at bytes 30 (CBW), 63, 127, … 1023 of data; CSW pass -> status 0; next command's CBW carries tag 2.
- len=0 read -> no data phase; CBW length field 00 00 00 00, flags 80; CSW received -> done.
- CSW with bCSWStatus=01 -> status 1; tag mismatch -> status 2; signature byte 0=0x56 -> status 2.
- out_ready toggled randomly during CBW -> out_data/out_last held stable while stalled; byte order unchanged.
- rst asserted mid-DATA_IN, then released -> outputs at reset values, cmd_ready=1, tag=1, no done pulse.
